// File: rtl/fp_recfn_pkg.sv
// Shared definitions for the recFN F32 divide/sqrt slice.
// Holds the recFN field positions, the special exponent codes, the exponent
// bias, the FSM state encoding, the iteration count and the registered raw
// result record.
package fp_recfn_pkg;

  localparam int REC_W     = 33;
  localparam int SIGN_BIT  = 32;
  localparam int EXP_MSB   = 31;
  localparam int EXP_LSB   = 23;
  localparam int FRACT_MSB = 22;

  // Top three exponent bits select the class of a recFN value.
  localparam logic [2:0] EXP_CODE_ZERO = 3'b000;
  localparam logic [2:0] EXP_CODE_INF  = 3'b110;
  localparam logic [2:0] EXP_CODE_NAN  = 3'b111;

  localparam logic [9:0] EXP_BIAS   = 10'd256;
  localparam logic [4:0] ITER_COUNT = 5'd25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Everything presented to the downstream rounder; held between DONE cycles.
  typedef struct packed {
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
    logic        sign;
    logic [9:0]  sexp;
    logic [26:0] sig;
    logic        invalid;
    logic        infinite;
    logic [2:0]  rm;
  } raw_out_t;

endpackage

// File: rtl/div_sqrt_raw_f32_if.sv
// Operation/result bus of the raw divide/sqrt unit.
// master: issues operations (inValid, sqrtOp, a, b, roundingMode) and
//         observes inReady plus the raw result and its valid pulses.
// slave : the unit itself.
interface div_sqrt_raw_f32_if;
  import fp_recfn_pkg::*;

  logic             io_inReady;
  logic             io_inValid;
  logic             io_sqrtOp;
  logic [REC_W-1:0] io_a;
  logic [REC_W-1:0] io_b;
  logic [2:0]       io_roundingMode;
  logic             io_rawOutValid_div;
  logic             io_rawOutValid_sqrt;
  logic [2:0]       io_roundingModeOut;
  logic             io_invalidExc;
  logic             io_infiniteExc;
  logic             io_rawOut_isNaN;
  logic             io_rawOut_isInf;
  logic             io_rawOut_isZero;
  logic             io_rawOut_sign;
  logic [9:0]       io_rawOut_sExp;
  logic [26:0]      io_rawOut_sig;

  modport master (
    input  io_inReady, io_rawOutValid_div, io_rawOutValid_sqrt,
           io_roundingModeOut, io_invalidExc, io_infiniteExc,
           io_rawOut_isNaN, io_rawOut_isInf, io_rawOut_isZero,
           io_rawOut_sign, io_rawOut_sExp, io_rawOut_sig,
    output io_inValid, io_sqrtOp, io_a, io_b, io_roundingMode
  );

  modport slave (
    output io_inReady, io_rawOutValid_div, io_rawOutValid_sqrt,
           io_roundingModeOut, io_invalidExc, io_infiniteExc,
           io_rawOut_isNaN, io_rawOut_isInf, io_rawOut_isZero,
           io_rawOut_sign, io_rawOut_sExp, io_rawOut_sig,
    input  io_inValid, io_sqrtOp, io_a, io_b, io_roundingMode
  );

endinterface

// File: rtl/rec_f32_classify.sv
// Combinational decode of one 33-bit recFN operand.
// rec_i    : recFN value
// is_*_o   : class flags (NaN, signalling NaN, infinity, zero)
// sign_o   : sign bit; exp_o: 9-bit recoded exponent
// sig_o    : significand with the hidden one, {1, fract}, value in [1,2)
module rec_f32_classify
  import fp_recfn_pkg::*;
(
  input  logic [REC_W-1:0] rec_i,
  output logic             is_nan_o,
  output logic             is_snan_o,
  output logic             is_inf_o,
  output logic             is_zero_o,
  output logic             sign_o,
  output logic [8:0]       exp_o,
  output logic [23:0]      sig_o
);

  logic [2:0] code;

  assign code      = rec_i[EXP_MSB -: 3];
  assign sign_o    = rec_i[SIGN_BIT];
  assign exp_o     = rec_i[EXP_MSB:EXP_LSB];
  assign sig_o     = {1'b1, rec_i[FRACT_MSB:0]};
  assign is_zero_o = (code == EXP_CODE_ZERO);
  assign is_inf_o  = (code == EXP_CODE_INF);
  assign is_nan_o  = (code == EXP_CODE_NAN);
  assign is_snan_o = is_nan_o && !rec_i[FRACT_MSB];

endmodule

// File: rtl/div_sqrt_raw_f32.sv
// Iterative radix-2 divide / square-root producing an unrounded raw result.
// clock, reset : sole clock; synchronous active-high reset
// bus (slave)  : ready/valid operation input, raw result (sign, 10-bit
//                sExp biased 256, 27-bit sig with sticky in bit 0), class
//                flags, exception flags and the captured rounding mode.
// Normal operands take 25 ITER cycles, one result bit each; special operands
// go straight to DONE. DONE pulses the valid of the operation type for one
// cycle while the registered raw outputs hold until the next DONE.
module div_sqrt_raw_f32
  import fp_recfn_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  div_sqrt_raw_f32_if.slave bus
);

  logic        a_nan, a_snan, a_inf, a_zero, a_sign;
  logic        b_nan, b_snan, b_inf, b_zero, b_sign;
  logic [8:0]  a_exp, b_exp;
  logic [23:0] a_sig, b_sig;

  rec_f32_classify u_cls_a (
    .rec_i(bus.io_a), .is_nan_o(a_nan), .is_snan_o(a_snan), .is_inf_o(a_inf),
    .is_zero_o(a_zero), .sign_o(a_sign), .exp_o(a_exp), .sig_o(a_sig)
  );

  rec_f32_classify u_cls_b (
    .rec_i(bus.io_b), .is_nan_o(b_nan), .is_snan_o(b_snan), .is_inf_o(b_inf),
    .is_zero_o(b_zero), .sign_o(b_sign), .exp_o(b_exp), .sig_o(b_sig)
  );

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_sqrt_q, is_sqrt_d;
  logic [2:0]  rm_q, rm_d;
  logic        sign_q, sign_d;
  logic [9:0]  sexp_q, sexp_d;
  logic [26:0] rem_q, rem_d;
  logic [23:0] divisor_q, divisor_d;
  logic [49:0] rad_q, rad_d;
  logic [24:0] quo_q, quo_d;
  raw_out_t    out_q, out_d;

  // Special-operand classification at accept time.
  logic div_invalid, div_nan, div_inf, div_zero, div_infinite, div_special;
  logic sq_invalid, sq_nan, sq_special, op_special;

  assign div_invalid  = a_snan || b_snan || (a_zero && b_zero) || (a_inf && b_inf);
  assign div_nan      = div_invalid || a_nan || b_nan;
  assign div_infinite = !a_nan && !a_inf && !a_zero && b_zero;
  assign div_inf      = (a_inf || b_zero) && !div_nan;
  assign div_zero     = (a_zero || b_inf) && !div_nan;
  assign div_special  = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
  // Any negative operand that is not a zero or a NaN is an invalid sqrt.
  assign sq_invalid   = a_snan || (a_sign && !a_zero && !a_nan);
  assign sq_nan       = sq_invalid || a_nan;
  assign sq_special   = a_nan || a_inf || a_zero || a_sign;
  assign op_special   = bus.io_sqrtOp ? sq_special : div_special;

  // Normal-path initial values.
  logic        div_pre, sq_odd;
  logic [25:0] div_rem0;
  logic [9:0]  div_sexp, sq_sexp;
  logic [8:0]  sq_exp_even;
  logic [49:0] sq_rad0;

  // Pre-shifting a smaller dividend keeps the first quotient bit at 2^0.
  assign div_pre     = (a_sig < b_sig);
  assign div_rem0    = div_pre ? {1'b0, a_sig, 1'b0} : {2'b00, a_sig};
  assign div_sexp    = {1'b0, a_exp} - {1'b0, b_exp} + EXP_BIAS - {9'd0, div_pre};
  // Bias 256 is even, so the parity of the unbiased exponent is exp[0].
  assign sq_odd      = a_exp[0];
  assign sq_exp_even = a_exp - {8'd0, sq_odd};
  assign sq_sexp     = {2'b00, sq_exp_even[8:1]} + 10'd128;
  // Radicand scaled by 2^48 so 25 two-bit steps yield a root with 24 fraction bits.
  assign sq_rad0     = sq_odd ? {a_sig, 26'd0} : {1'b0, a_sig, 25'd0};

  // One recurrence step.
  logic        div_ge, sq_ge, q_bit;
  logic [26:0] div_sub, sq_shift, sq_trial, sq_sub, rem_next;
  logic [24:0] quo_next;

  assign div_ge   = (rem_q >= {3'd0, divisor_q});
  assign div_sub  = div_ge ? (rem_q - {3'd0, divisor_q}) : rem_q;
  assign sq_shift = (rem_q << 2) | {25'd0, rad_q[49:48]};
  assign sq_trial = {quo_q, 2'b01};
  assign sq_ge    = (sq_shift >= sq_trial);
  assign sq_sub   = sq_ge ? (sq_shift - sq_trial) : sq_shift;
  assign q_bit    = is_sqrt_q ? sq_ge : div_ge;
  assign quo_next = {quo_q[23:0], q_bit};
  assign rem_next = is_sqrt_q ? sq_sub : (div_sub << 1);

  // NOTE: every variable gets its hold value first so no path through the
  // case leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_sqrt_d = is_sqrt_q;
    rm_d      = rm_q;
    sign_d    = sign_q;
    sexp_d    = sexp_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    rad_d     = rad_q;
    quo_d     = quo_q;
    out_d     = out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.io_inValid) begin
          is_sqrt_d = bus.io_sqrtOp;
          rm_d      = bus.io_roundingMode;
          quo_d     = '0;
          divisor_d = b_sig;
          if (bus.io_sqrtOp) begin
            sign_d = 1'b0;
            sexp_d = sq_sexp;
            rem_d  = '0;
            rad_d  = sq_rad0;
          end else begin
            sign_d = a_sign ^ b_sign;
            sexp_d = div_sexp;
            rem_d  = {1'b0, div_rem0};
          end
          if (op_special) begin
            out_d    = '0;
            out_d.rm = bus.io_roundingMode;
            if (bus.io_sqrtOp) begin
              out_d.invalid = sq_invalid;
              out_d.is_nan  = sq_nan;
              out_d.is_inf  = a_inf && !a_sign;
              out_d.is_zero = a_zero;
              out_d.sign    = a_zero && a_sign;
            end else begin
              out_d.invalid  = div_invalid;
              out_d.is_nan   = div_nan;
              out_d.infinite = div_infinite;
              out_d.is_inf   = div_inf;
              out_d.is_zero  = div_zero;
              out_d.sign     = a_sign ^ b_sign;
            end
            state_d = ST_DONE;
          end else begin
            cnt_d   = ITER_COUNT - 5'd1;
            state_d = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        rem_d = rem_next;
        quo_d = quo_next;
        rad_d = rad_q << 2;
        if (cnt_q == 5'd0) begin
          out_d      = '0;
          out_d.rm   = rm_q;
          out_d.sign = sign_q;
          out_d.sexp = sexp_q;
          out_d.sig  = {1'b0, quo_next, |rem_next};
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_sqrt_q <= 1'b0;
      rm_q      <= '0;
      sign_q    <= 1'b0;
      sexp_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      rad_q     <= '0;
      quo_q     <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_sqrt_q <= is_sqrt_d;
      rm_q      <= rm_d;
      sign_q    <= sign_d;
      sexp_q    <= sexp_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      rad_q     <= rad_d;
      quo_q     <= quo_d;
      out_q     <= out_d;
    end
  end

  // Reset during DONE aborts the operation, so it also masks that cycle's pulse.
  assign bus.io_inReady          = (state_q == ST_IDLE);
  assign bus.io_rawOutValid_div  = (state_q == ST_DONE) && !is_sqrt_q && !reset;
  assign bus.io_rawOutValid_sqrt = (state_q == ST_DONE) && is_sqrt_q && !reset;
  assign bus.io_roundingModeOut  = out_q.rm;
  assign bus.io_invalidExc       = out_q.invalid;
  assign bus.io_infiniteExc      = out_q.infinite;
  assign bus.io_rawOut_isNaN     = out_q.is_nan;
  assign bus.io_rawOut_isInf     = out_q.is_inf;
  assign bus.io_rawOut_isZero    = out_q.is_zero;
  assign bus.io_rawOut_sign      = out_q.sign;
  assign bus.io_rawOut_sExp      = out_q.sexp;
  assign bus.io_rawOut_sig       = out_q.sig;

endmodule
